pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Multi-cycle sequencer that owns the architectural PC register.
- Each instruction goes through the same steps: issue a fetch to instruction memory with a req/ack handshake, present the instruction, then wait for the datapath.
- While the instruction is presented, the next-PC logic produces next_pc_i combinationally from pc_o, and the sequencer commits it.
- A misaligned next PC raises a trap instead of being committed; after the trap is acknowledged, fetch resumes at a fixed trap vector.

Parameters:
- N, 32, PC/address/instruction width.
- RESET_VECTOR, 32'h0040_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0040_0100, PC loaded after a trap is acknowledged.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- fetch_req_o  out  1  fetch request to instruction memory; address is pc_o.
- fetch_ack_i  in  1  instruction memory has data on instr_i this cycle.
- instr_i  in  N  instruction word from memory; sampled only when fetch_ack_i is high in FETCH.
- instr_o  out  N  latched instruction presented to the decoder.
- instr_valid_o  out  1  instr_o is valid; high only in EXEC.
- pc_o  out  N  current PC, registered.
- next_pc_i  in  N  next PC computed by the PC-control datapath from pc_o and instr_o.
- stall_i  in  1  datapath not ready to retire; honoured only in EXEC.
- trap_o  out  1  misaligned-target trap pending.
- trap_ack_i  in  1  trap acknowledged by the trap handler.
- epc_o  out  N  PC of the instruction that produced the misaligned target.
- bad_addr_o  out  N  the offending next_pc_i value.
- retired_o  out  N  count of committed instructions.

Behaviour:
- Reset (rst_i high at an edge, takes priority over everything):
  - state=BOOT, pc_o=RESET_VECTOR, instr_o=0, epc_o=0, bad_addr_o=0, retired_o=0.
  - fetch_req_o=0, instr_valid_o=0, trap_o=0.
  - Reset in any state abandons the outstanding fetch or trap with no side effect.
- States:
  - BOOT: one cycle, fetch_req_o=0; unconditional transition to FETCH.
  - FETCH: fetch_req_o=1, pc_o held stable. On fetch_ack_i: instr_o<=instr_i, go to EXEC. Without ack, remain indefinitely.
  - EXEC: fetch_req_o=0, instr_valid_o=1.
    - stall_i=1: hold all state.
    - stall_i=0 and next_pc_i[1:0]==2'b00: pc_o<=next_pc_i, retired_o<=retired_o+1, go to FETCH.
    - stall_i=0 and next_pc_i[1:0]!=2'b00: epc_o<=pc_o, bad_addr_o<=next_pc_i, go to TRAP. pc_o and retired_o are not updated.
  - TRAP: trap_o=1, fetch_req_o=0, instr_valid_o=0. On trap_ack_i: pc_o<=TRAP_VECTOR, go to FETCH (trap_o drops the same edge).
- Outputs:
  - fetch_req_o, instr_valid_o and trap_o are Moore decodes of state.
  - All other outputs are registers.
- Input qualification:
  - fetch_ack_i is ignored outside FETCH.
  - stall_i and next_pc_i are ignored outside EXEC.
  - trap_ack_i is ignored outside TRAP.
- Latency:
  - Minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC with no stall).
  - Each cycle of memory wait or stall adds one cycle.
- Arithmetic:
  - retired_o wraps modulo 2^N (2^N-1 -> 0).
  - next_pc_i is committed verbatim; no masking or arithmetic in this block.
- Boundaries:
  - A self-loop (next_pc_i==pc_o) is legal and re-fetches the same address.
  - next_pc_i wrapping past the top of the address space is committed as given.
  - epc_o and bad_addr_o hold their values until the next trap or reset.

Test Plan:
- Reset, then fetch_ack_i tied high: pc_o=0x00400000, fetch_req_o rises 1 cycle after reset deasserts, instr_valid_o rises next cycle. With next_pc_i=pc_o+4 and no stall: pc_o steps 0x00400000 -> 0x00400004 -> 0x00400008 every 2 cycles; retired_o = 1, 2, ….
- Memory wait: fetch_ack_i low for 3 cycles in FETCH -> pc_o and fetch_req_o hold for 3 cycles, instr_valid_o stays 0, instr_o captures instr_i=0x00A00093 on the ack cycle.
- Stall: stall_i=1 for 4 cycles in EXEC with next_pc_i=0x00400040 -> pc_o, instr_o and retired_o unchanged for 4 cycles; pc_o=0x00400040 on the edge after stall_i falls.
- Misaligned jump: at pc_o=0x00400010, next_pc_i=0x00400022 -> trap_o=1, epc_o=0x00400010, bad_addr_o=0x00400022, retired_o unchanged. trap_ack_i after 2 cycles -> pc_o=0x00400100, FETCH resumes.
- Reset mid-FETCH with fetch_ack_i high on the same edge -> ack ignored; pc_o=0x00400000, state BOOT, retired_o=0.
- Counter wrap: force retired_o to 0xFFFFFFFF (via a preloaded run or bench force) and retire one instruction -> retired_o=0x00000000.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer_if
// Brief    : Fetch, decode-presentation and trap signals of the PC sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pc_fetch_sequencer_if #(
    parameter int unsigned N = 32
);
    logic         fetch_req_o;
    logic         fetch_ack_i;
    logic [N-1:0] instr_i;
    logic [N-1:0] instr_o;
    logic         instr_valid_o;
    logic [N-1:0] pc_o;
    logic [N-1:0] next_pc_i;
    logic         stall_i;
    logic         trap_o;
    logic         trap_ack_i;
    logic [N-1:0] epc_o;
    logic [N-1:0] bad_addr_o;
    logic [N-1:0] retired_o;

    // Sequencer side
    modport master (
        output fetch_req_o, instr_o, instr_valid_o, pc_o, trap_o,
               epc_o, bad_addr_o, retired_o,
        input  fetch_ack_i, instr_i, next_pc_i, stall_i, trap_ack_i
    );

    // Memory / datapath / trap-handler side
    modport slave (
        input  fetch_req_o, instr_o, instr_valid_o, pc_o, trap_o,
               epc_o, bad_addr_o, retired_o,
        output fetch_ack_i, instr_i, next_pc_i, stall_i, trap_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Brief    : Multi-cycle fetch/exec sequencer owning the architectural PC,
//            with misaligned-target trap and retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter int unsigned  N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [N-1:0] TRAP_VECTOR  = 32'h0040_0100
) (
    input  wire                   clk_i,
    input  wire                   rst_i,
    pc_fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t       r_state;
    logic         r_fetch_req;
    logic         r_instr_valid;
    logic         r_trap;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_instr;
    logic [N-1:0] r_epc;
    logic [N-1:0] r_bad_addr;
    logic [N-1:0] r_retired;

    logic         w_misaligned;

    assign w_misaligned = (bus.next_pc_i[1:0] != 2'b00);

    // Moore flags are registered alongside the state so they decode it exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_BOOT;
            r_fetch_req   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_trap        <= 1'b0;
            r_pc          <= RESET_VECTOR;
            r_instr       <= '0;
            r_epc         <= '0;
            r_bad_addr    <= '0;
            r_retired     <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state     <= S_FETCH;
                    r_fetch_req <= 1'b1;
                end
                S_FETCH: begin
                    if (bus.fetch_ack_i) begin
                        r_instr       <= bus.instr_i;
                        r_state       <= S_EXEC;
                        r_fetch_req   <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!bus.stall_i) begin
                        r_instr_valid <= 1'b0;
                        if (!w_misaligned) begin
                            r_pc        <= bus.next_pc_i;
                            r_retired   <= r_retired + N'(1);
                            r_state     <= S_FETCH;
                            r_fetch_req <= 1'b1;
                        end else begin
                            r_epc      <= r_pc;
                            r_bad_addr <= bus.next_pc_i;
                            r_state    <= S_TRAP;
                            r_trap     <= 1'b1;
                        end
                    end
                end
                S_TRAP: begin
                    if (bus.trap_ack_i) begin
                        r_pc        <= TRAP_VECTOR;
                        r_state     <= S_FETCH;
                        r_trap      <= 1'b0;
                        r_fetch_req <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_BOOT;
                    r_fetch_req   <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_trap        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_req_o   = r_fetch_req;
    assign bus.instr_valid_o = r_instr_valid;
    assign bus.trap_o        = r_trap;
    assign bus.pc_o          = r_pc;
    assign bus.instr_o       = r_instr;
    assign bus.epc_o         = r_epc;
    assign bus.bad_addr_o    = r_bad_addr;
    assign bus.retired_o     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_sequencer
// Brief    : Scoreboard bench: transaction-level model feeds expected queues,
//            an independent monitor pops and compares on DUT output events.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    localparam logic [31:0] c_reset_vec = 32'h0040_0000;
    localparam logic [31:0] c_trap_vec  = 32'h0040_0100;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_sequencer_if #(.N(32)) bus ();

    pc_fetch_sequencer #(
        .N            (32),
        .RESET_VECTOR (c_reset_vec),
        .TRAP_VECTOR  (c_trap_vec)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expected queues: fetch entry {pc, retired}, exec entry {pc, instr},
    // trap entry {epc, bad_addr, retired}
    rec_t q_fetch[$];
    rec_t q_instr[$];
    rec_t q_trap[$];

    logic [31:0] m_pc;
    logic [31:0] m_ret;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // ---------------- monitor ----------------
    logic        pf = 1'b0, pv = 1'b0, pt = 1'b0;
    logic [31:0] cur_pc, cur_instr;
    rec_t        me;

    initial begin
        cur_pc    = '0;
        cur_instr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.fetch_req_o && !pf) begin
                if (q_fetch.size() == 0) chk1("unexpected_fetch", 1'b1, 1'b0);
                else begin
                    me = q_fetch.pop_front();
                    chk32("fetch_pc", bus.pc_o, me.a);
                    chk32("fetch_retired", bus.retired_o, me.b);
                    cur_pc = me.a;
                end
            end
            if (bus.fetch_req_o) chk32("fetch_pc_hold", bus.pc_o, cur_pc);
            if (bus.instr_valid_o && !pv) begin
                if (q_instr.size() == 0) chk1("unexpected_exec", 1'b1, 1'b0);
                else begin
                    me = q_instr.pop_front();
                    chk32("exec_pc", bus.pc_o, me.a);
                    chk32("exec_instr", bus.instr_o, me.b);
                    cur_instr = me.b;
                end
            end
            if (bus.instr_valid_o) begin
                chk32("exec_instr_hold", bus.instr_o, cur_instr);
                chk32("exec_pc_hold", bus.pc_o, cur_pc);
            end
            if (bus.trap_o && !pt) begin
                if (q_trap.size() == 0) chk1("unexpected_trap", 1'b1, 1'b0);
                else begin
                    me = q_trap.pop_front();
                    chk32("trap_epc", bus.epc_o, me.a);
                    chk32("trap_bad_addr", bus.bad_addr_o, me.b);
                    chk32("trap_retired", bus.retired_o, me.c);
                    chk32("trap_pc_unchanged", bus.pc_o, me.a);
                end
            end
            chk1("state_flags_exclusive",
                 (32'(bus.fetch_req_o) + 32'(bus.instr_valid_o) + 32'(bus.trap_o)) > 1, 1'b0);
            pf = bus.fetch_req_o;
            pv = bus.instr_valid_o;
            pt = bus.trap_o;
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic wait_fetch();
        int n = 0;
        while (!bus.fetch_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.fetch_req_o) begin
            n_checks++;
            $display("FAIL fetch_timeout: fetch_req_o=0 expected 1 within 20 cycles");
            finish_run();
        end
    endtask

    task automatic noise_inputs();
        bus.stall_i    = 1'($urandom_range(0, 1));
        bus.next_pc_i  = $urandom;
        bus.trap_ack_i = 1'($urandom_range(0, 1));
    endtask

    task automatic run_instr(input logic [31:0] npc, input logic [31:0] ins,
                             input int waits, input int stalls, input int ack_wait);
        wait_fetch();
        bus.fetch_ack_i = 1'b0;
        repeat (waits) begin
            noise_inputs();
            @(negedge clk);
            chk1("fetch_wait_hold", bus.fetch_req_o, 1'b1);
        end
        noise_inputs();
        bus.instr_i     = ins;
        bus.fetch_ack_i = 1'b1;
        q_instr.push_back('{a: m_pc, b: ins, c: 32'd0});
        @(negedge clk);
        bus.trap_ack_i = 1'($urandom_range(0, 1));
        bus.instr_i    = $urandom;
        chk1("exec_entry", bus.instr_valid_o, 1'b1);
        repeat (stalls) begin
            bus.stall_i     = 1'b1;
            bus.next_pc_i   = $urandom;
            bus.fetch_ack_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk1("stall_hold", bus.instr_valid_o, 1'b1);
            chk32("stall_retired", bus.retired_o, m_ret);
        end
        bus.stall_i     = 1'b0;
        bus.next_pc_i   = npc;
        bus.fetch_ack_i = 1'($urandom_range(0, 1));
        if (npc[1:0] == 2'b00) begin
            m_pc  = npc;
            m_ret = m_ret + 32'd1;
            q_fetch.push_back('{a: m_pc, b: m_ret, c: 32'd0});
            @(negedge clk);
            bus.fetch_ack_i = 1'b0;
            bus.trap_ack_i  = 1'b0;
            chk1("commit_refetch", bus.fetch_req_o, 1'b1);
        end else begin
            q_trap.push_back('{a: m_pc, b: npc, c: m_ret});
            @(negedge clk);
            chk1("trap_entry", bus.trap_o, 1'b1);
            bus.trap_ack_i = 1'b0;
            repeat (ack_wait) begin
                bus.stall_i     = 1'($urandom_range(0, 1));
                bus.next_pc_i   = $urandom;
                bus.fetch_ack_i = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk1("trap_wait_hold", bus.trap_o, 1'b1);
            end
            bus.trap_ack_i  = 1'b1;
            bus.fetch_ack_i = 1'b0;
            m_pc = c_trap_vec;
            q_fetch.push_back('{a: m_pc, b: m_ret, c: 32'd0});
            @(negedge clk);
            bus.trap_ack_i = 1'b0;
            chk1("trap_exit_fetch", bus.fetch_req_o, 1'b1);
            chk1("trap_exit_drop", bus.trap_o, 1'b0);
        end
        bus.stall_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk32({tag, "_pc"}, bus.pc_o, c_reset_vec);
        chk32({tag, "_instr"}, bus.instr_o, 32'd0);
        chk32({tag, "_epc"}, bus.epc_o, 32'd0);
        chk32({tag, "_bad_addr"}, bus.bad_addr_o, 32'd0);
        chk32({tag, "_retired"}, bus.retired_o, 32'd0);
        chk1({tag, "_fetch_req"}, bus.fetch_req_o, 1'b0);
        chk1({tag, "_instr_valid"}, bus.instr_valid_o, 1'b0);
        chk1({tag, "_trap"}, bus.trap_o, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] npc;
        int          sel;

        bus.fetch_ack_i = 1'b0;
        bus.instr_i     = '0;
        bus.next_pc_i   = '0;
        bus.stall_i     = 1'b0;
        bus.trap_ack_i  = 1'b0;
        m_pc  = c_reset_vec;
        m_ret = 32'd0;
        q_fetch.push_back('{a: c_reset_vec, b: 32'd0, c: 32'd0});
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk1("fetch_after_reset", bus.fetch_req_o, 1'b1);

        // Back-to-back two-cycle instructions
        repeat (3) run_instr(m_pc + 32'd4, $urandom, 0, 0, 0);
        chk32("pc_step3", m_pc, 32'h0040_000C);
        // Memory wait
        run_instr(m_pc + 32'd4, 32'h00A0_0093, 3, 0, 0);
        // Stall then jump
        run_instr(32'h0040_0040, $urandom, 0, 4, 0);
        // Misaligned jump from 0x00400010
        run_instr(32'h0040_0010, $urandom, 1, 0, 0);
        run_instr(32'h0040_0022, $urandom, 0, 0, 2);
        // Self-loop and address-space wrap
        run_instr(m_pc, $urandom, 0, 1, 0);
        run_instr(32'hFFFF_FFFC, $urandom, 0, 0, 0);
        run_instr(m_pc + 32'd4, $urandom, 0, 0, 0);

        // Counter wrap
        wait_fetch();
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        m_ret = 32'hFFFF_FFFF;
        run_instr(m_pc + 32'd4, $urandom, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r   = $urandom;
            sel = $urandom_range(0, 99);
            if (sel < 65)      npc = m_pc + 32'd4;
            else if (sel < 80) npc = {r[31:2], 2'b00};
            else               npc = {r[31:2], 2'b01 + 2'($urandom_range(0, 2))};
            run_instr(npc, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3));
        end

        // Reset in FETCH with a simultaneous ack
        wait_fetch();
        bus.fetch_ack_i = 1'b1;
        bus.instr_i     = $urandom | 32'h1;
        rst             = 1'b1;
        q_fetch.delete();
        q_instr.delete();
        q_trap.delete();
        m_pc  = c_reset_vec;
        m_ret = 32'd0;
        q_fetch.push_back('{a: c_reset_vec, b: 32'd0, c: 32'd0});
        @(negedge clk);
        check_reset_outputs("midfetch_reset");
        rst             = 1'b0;
        bus.fetch_ack_i = 1'b0;
        @(negedge clk);
        chk1("fetch_after_midreset", bus.fetch_req_o, 1'b1);
        repeat (3) run_instr(m_pc + 32'd4, $urandom, $urandom_range(0, 2), 0, 0);

        repeat (2) @(negedge clk);
        chk32("q_fetch_drained", 32'(q_fetch.size()), 32'd0);
        chk32("q_instr_drained", 32'(q_instr.size()), 32'd0);
        chk32("q_trap_drained", 32'(q_trap.size()), 32'd0);
        finish_run();
    end

    initial begin
        #500000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
